// File: rtl/sound_arbiter.sv
// Shares one piezo tone generator between alarm, keypad click and lullaby sources.
// Fixed priority with preemption, a silence gap on every ownership change, built-in click timer.
module sound_arbiter #(
    parameter logic [12:0] CLICK_TONE   = 13'd1,
    parameter int unsigned CLICK_CYCLES = 2500000,
    parameter int unsigned GAP_CYCLES   = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alarm_req,
    input  logic [12:0] alarm_beat,
    input  logic        lull_req,
    input  logic [12:0] lull_beat,
    input  logic        key_valid,
    input  logic        mute,
    output logic [12:0] play_sound,
    output logic [2:0]  grant,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        PLAY_ALARM,
        PLAY_CLICK,
        PLAY_LULL,
        GAP
    } state_t;

    localparam logic [21:0] CLICK_LOAD = 22'(CLICK_CYCLES - 1);
    localparam logic [21:0] GAP_LOAD   = 22'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [21:0] count_q, count_d;
    logic        clickPend_q, clickPend_d;
    logic [2:0]  grant_q, grant_d;
    logic [12:0] sound_q, sound_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            clickPend_q <= 1'b0;
            grant_q     <= 3'b000;
            sound_q     <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            clickPend_q <= clickPend_d;
            grant_q     <= grant_d;
            sound_q     <= sound_d;
        end
    end

    // Every exit from a PLAY state passes through GAP, so IDLE never hands over directly.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (alarm_req) begin
                    state_d = PLAY_ALARM;
                end else if (clickPend_q) begin
                    state_d = PLAY_CLICK;
                    count_d = CLICK_LOAD;
                end else if (lull_req) begin
                    state_d = PLAY_LULL;
                end
            end
            PLAY_ALARM: begin
                if (!alarm_req) begin
                    state_d = GAP;
                    count_d = GAP_LOAD;
                end
            end
            PLAY_CLICK: begin
                if (alarm_req || count_q == '0) begin
                    state_d = GAP;
                    count_d = GAP_LOAD;
                end else begin
                    count_d = count_q - 22'd1;
                end
            end
            PLAY_LULL: begin
                if (alarm_req || clickPend_q || !lull_req) begin
                    state_d = GAP;
                    count_d = GAP_LOAD;
                end
            end
            GAP: begin
                if (count_q == '0) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q - 22'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Key presses while the alarm owns or wants the piezo are discarded, not queued.
    always_comb begin
        clickPend_d = clickPend_q;
        if (state_d == PLAY_CLICK && state_q != PLAY_CLICK) begin
            clickPend_d = 1'b0;
        end else if (key_valid && (alarm_req || state_q == PLAY_ALARM)) begin
            clickPend_d = 1'b0;
        end else if (key_valid) begin
            clickPend_d = 1'b1;
        end
    end

    always_comb begin
        grant_d = 3'b000;
        case (state_d)
            PLAY_ALARM: grant_d = 3'b100;
            PLAY_CLICK: grant_d = 3'b010;
            PLAY_LULL:  grant_d = 3'b001;
            default:    grant_d = 3'b000;
        endcase
    end

    always_comb begin
        sound_d = '0;
        if (!mute) begin
            case (state_q)
                PLAY_ALARM: sound_d = alarm_beat;
                PLAY_CLICK: sound_d = CLICK_TONE;
                PLAY_LULL:  sound_d = lull_beat;
                default:    sound_d = '0;
            endcase
        end
    end

    assign play_sound = sound_q;
    assign grant      = grant_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sound_arbiter.sv
// Self-checking bench for sound_arbiter: directed vector table, randomized run against
// an ownership-level reference model, and an asynchronous reset abort mid-click.
module tb_sound_arbiter;

    localparam int          CLICK = 8;
    localparam int          GAP   = 4;
    localparam logic [12:0] TONE  = 13'd1;

    localparam int NONE    = 0;
    localparam int ALARM   = 1;
    localparam int CLK_SRC = 2;
    localparam int LULL    = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        alarm_req;
    logic [12:0] alarm_beat;
    logic        lull_req;
    logic [12:0] lull_beat;
    logic        key_valid;
    logic        mute;
    logic [12:0] play_sound;
    logic [2:0]  grant;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: who owns the piezo, how much gap/click time remains, pending click.
    int          mOwner;
    int          mGapLeft;
    int          mClickLeft;
    bit          mPend;
    logic [12:0] mSound;

    typedef struct {
        logic        aReq;
        logic [12:0] aBeat;
        logic        lReq;
        logic [12:0] lBeat;
        logic        kv;
        logic        mt;
        int          cycles;
        logic [2:0]  eGrant;
        logic [12:0] eSound;
        logic        eBusy;
    } vec_t;

    vec_t vecs[$];

    sound_arbiter #(
        .CLICK_TONE  (TONE),
        .CLICK_CYCLES(CLICK),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .alarm_req  (alarm_req),
        .alarm_beat (alarm_beat),
        .lull_req   (lull_req),
        .lull_beat  (lull_beat),
        .key_valid  (key_valid),
        .mute       (mute),
        .play_sound (play_sound),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    function automatic void modelReset();
        mOwner     = NONE;
        mGapLeft   = 0;
        mClickLeft = 0;
        mPend      = 1'b0;
        mSound     = '0;
    endfunction

    function automatic logic [2:0] modelGrant();
        case (mOwner)
            ALARM:   return 3'b100;
            CLK_SRC: return 3'b010;
            LULL:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic modelBusy();
        return (mOwner != NONE) || (mGapLeft > 0);
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void modelStep();
        logic [12:0] snd;
        int          oldOwner;
        bit          entering;
        snd      = '0;
        oldOwner = mOwner;
        entering = 1'b0;
        if (!mute) begin
            if (mOwner == ALARM)        snd = alarm_beat;
            else if (mOwner == CLK_SRC) snd = TONE;
            else if (mOwner == LULL)    snd = lull_beat;
        end
        if (mGapLeft > 0) begin
            mGapLeft = mGapLeft - 1;
        end else if (mOwner == NONE) begin
            if (alarm_req) begin
                mOwner = ALARM;
            end else if (mPend) begin
                mOwner     = CLK_SRC;
                mClickLeft = CLICK;
                entering   = 1'b1;
            end else if (lull_req) begin
                mOwner = LULL;
            end
        end else if (mOwner == ALARM) begin
            if (!alarm_req) begin
                mOwner   = NONE;
                mGapLeft = GAP;
            end
        end else if (mOwner == CLK_SRC) begin
            mClickLeft = mClickLeft - 1;
            if (alarm_req || mClickLeft == 0) begin
                mOwner   = NONE;
                mGapLeft = GAP;
            end
        end else begin
            if (alarm_req || mPend || !lull_req) begin
                mOwner   = NONE;
                mGapLeft = GAP;
            end
        end
        if (entering) mPend = 1'b0;
        else if (key_valid && (alarm_req || oldOwner == ALARM)) mPend = 1'b0;
        else if (key_valid) mPend = 1'b1;
        mSound = snd;
    endfunction

    task automatic checkOutput(input string name, input logic [2:0] eGrant,
                               input logic [12:0] eSound, input logic eBusy);
        compared = compared + 3;
        if (grant !== eGrant) begin
            mismatched++;
            $display("[TB] FAIL %s grant: got %b expected %b", name, grant, eGrant);
        end
        if (play_sound !== eSound) begin
            mismatched++;
            $display("[TB] FAIL %s play_sound: got %0d expected %0d", name, play_sound, eSound);
        end
        if (busy !== eBusy) begin
            mismatched++;
            $display("[TB] FAIL %s busy: got %b expected %b", name, busy, eBusy);
        end
    endtask

    // One clock edge, with the model stepped in lockstep and compared just after the edge.
    task automatic cycle(input string name);
        @(posedge clock);
        modelStep();
        #1;
        checkOutput(name, modelGrant(), mSound, modelBusy());
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        alarm_req  = v.aReq;
        alarm_beat = v.aBeat;
        lull_req   = v.lReq;
        lull_beat  = v.lBeat;
        key_valid  = v.kv;
        mute       = v.mt;
        for (int c = 0; c < v.cycles; c++) begin
            cycle($sformatf("vec%0d_model", idx));
            key_valid = 1'b0;
        end
        checkOutput($sformatf("vec%0d_table", idx), v.eGrant, v.eSound, v.eBusy);
    endtask

    task automatic clearInputs();
        alarm_req  = 1'b0;
        alarm_beat = '0;
        lull_req   = 1'b0;
        lull_beat  = '0;
        key_valid  = 1'b0;
        mute       = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clearInputs();
        modelReset();

        // Fields: aReq aBeat lReq lBeat kv mute cycles | grant sound busy
        vecs.push_back('{1'b0, 13'd0,   1'b1, 13'd42, 1'b0, 1'b0, 1, 3'b001, 13'd0,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b1, 13'd42, 1'b0, 1'b0, 1, 3'b001, 13'd42,  1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b0, 13'd42, 1'b0, 1'b0, 1, 3'b000, 13'd42,  1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b0, 13'd42, 1'b0, 1'b0, 4, 3'b000, 13'd0,   1'b0});
        vecs.push_back('{1'b0, 13'd0,   1'b0, 13'd0,  1'b1, 1'b0, 1, 3'b000, 13'd0,   1'b0});
        vecs.push_back('{1'b0, 13'd0,   1'b0, 13'd0,  1'b0, 1'b0, 1, 3'b010, 13'd0,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b0, 13'd0,  1'b0, 1'b0, 1, 3'b010, 13'd1,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b0, 13'd0,  1'b0, 1'b0, 7, 3'b000, 13'd1,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b0, 13'd0,  1'b0, 1'b0, 1, 3'b000, 13'd0,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b0, 13'd0,  1'b0, 1'b0, 4, 3'b000, 13'd0,   1'b0});
        vecs.push_back('{1'b0, 13'd0,   1'b1, 13'd7,  1'b0, 1'b0, 2, 3'b001, 13'd7,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b1, 13'd7,  1'b1, 1'b0, 1, 3'b001, 13'd7,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b1, 13'd7,  1'b0, 1'b0, 1, 3'b000, 13'd7,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b1, 13'd7,  1'b0, 1'b0, 4, 3'b000, 13'd0,   1'b0});
        vecs.push_back('{1'b0, 13'd0,   1'b1, 13'd7,  1'b0, 1'b0, 1, 3'b010, 13'd0,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b1, 13'd7,  1'b0, 1'b0, 8, 3'b000, 13'd1,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b1, 13'd7,  1'b0, 1'b0, 5, 3'b001, 13'd0,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b1, 13'd7,  1'b0, 1'b0, 1, 3'b001, 13'd7,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b0, 13'd7,  1'b1, 1'b0, 1, 3'b000, 13'd7,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b0, 13'd7,  1'b0, 1'b0, 5, 3'b010, 13'd0,   1'b1});
        vecs.push_back('{1'b0, 13'd0,   1'b0, 13'd7,  1'b0, 1'b0, 2, 3'b010, 13'd1,   1'b1});
        vecs.push_back('{1'b1, 13'd100, 1'b0, 13'd7,  1'b0, 1'b0, 1, 3'b000, 13'd1,   1'b1});
        vecs.push_back('{1'b1, 13'd100, 1'b0, 13'd7,  1'b0, 1'b0, 4, 3'b000, 13'd0,   1'b0});
        vecs.push_back('{1'b1, 13'd100, 1'b0, 13'd7,  1'b0, 1'b0, 1, 3'b100, 13'd0,   1'b1});
        vecs.push_back('{1'b1, 13'd100, 1'b0, 13'd7,  1'b1, 1'b0, 1, 3'b100, 13'd100, 1'b1});
        vecs.push_back('{1'b1, 13'd100, 1'b0, 13'd7,  1'b0, 1'b0, 1, 3'b100, 13'd100, 1'b1});
        vecs.push_back('{1'b1, 13'd100, 1'b0, 13'd7,  1'b1, 1'b0, 1, 3'b100, 13'd100, 1'b1});
        vecs.push_back('{1'b1, 13'd100, 1'b0, 13'd7,  1'b0, 1'b0, 1, 3'b100, 13'd100, 1'b1});
        vecs.push_back('{1'b1, 13'd100, 1'b0, 13'd7,  1'b1, 1'b0, 1, 3'b100, 13'd100, 1'b1});
        vecs.push_back('{1'b1, 13'd100, 1'b0, 13'd7,  1'b0, 1'b1, 1, 3'b100, 13'd0,   1'b1});
        vecs.push_back('{1'b1, 13'd100, 1'b0, 13'd7,  1'b0, 1'b1, 9, 3'b100, 13'd0,   1'b1});
        vecs.push_back('{1'b1, 13'd100, 1'b0, 13'd7,  1'b0, 1'b0, 1, 3'b100, 13'd100, 1'b1});
        vecs.push_back('{1'b1, 13'd200, 1'b0, 13'd7,  1'b0, 1'b0, 1, 3'b100, 13'd200, 1'b1});
        vecs.push_back('{1'b0, 13'd200, 1'b0, 13'd7,  1'b0, 1'b0, 1, 3'b000, 13'd200, 1'b1});
        vecs.push_back('{1'b0, 13'd200, 1'b0, 13'd7,  1'b0, 1'b0, 5, 3'b000, 13'd0,   1'b0});

        // Reset state while reset is held low.
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_state", 3'b000, 13'd0, 1'b0);
        reset = 1'b1;

        $display("[TB] directed vector table, %0d entries", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Randomized traffic checked against the model every cycle.
        $display("[TB] randomized run");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) alarm_req = ~alarm_req;
            if ($urandom_range(14) == 0) lull_req = ~lull_req;
            if ($urandom_range(3) == 0) alarm_beat = 13'($urandom);
            if ($urandom_range(3) == 0) lull_beat = 13'($urandom);
            key_valid = ($urandom_range(11) == 0);
            mute      = ($urandom_range(9) == 0);
            cycle("random");
        end

        // Let any ownership drain, then abort a click with an asynchronous reset.
        clearInputs();
        repeat (30) cycle("drain");
        checkOutput("drained_idle", 3'b000, 13'd0, 1'b0);
        key_valid = 1'b1;
        cycle("abort_key");
        key_valid = 1'b0;
        repeat (3) cycle("abort_click");
        checkOutput("click_before_abort", 3'b010, TONE, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("async_abort", 3'b000, 13'd0, 1'b0);
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (5) cycle("post_reset");
        checkOutput("post_reset_idle", 3'b000, 13'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
